// File: rtl/sdram_traffic_gen.sv
// Burst write/read-back self-test initiator for sdram_ctrl: writes an incrementing
// pattern over NUM_BURSTS bursts, reads it back, and reports mismatches and ack timeouts.
module sdram_traffic_gen #(
  parameter logic [23:0] BASE_ADDR   = 24'h00_0000,
  parameter int          BURST_LEN   = 10,
  parameter int          NUM_BURSTS  = 4,
  parameter logic [15:0] DATA_SEED   = 16'h0000,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk_100m,
  input  logic        rstn,
  input  logic        start,
  output logic        wr_req,
  output logic [23:0] wr_addr,
  output logic [9:0]  wr_burst_len,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_data,
  input  logic        rd_ack,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic        timeout
);

  localparam int              WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [23:0]     STRIDE  = 24'(BURST_LEN);
  localparam logic [9:0]      W_LAST  = 10'(BURST_LEN - 1);
  localparam logic [7:0]      B_LAST  = 8'(NUM_BURSTS - 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BURST, S_WR_GAP, S_RD_BURST, S_RD_GAP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [23:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [15:0]     wr_data_q, wr_data_d, exp_q, exp_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      burst_q, burst_d;
  logic [9:0]      word_q, word_d;
  logic [WDW-1:0]  wdog_q, wdog_d;

  always_ff @(posedge clk_100m or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      rd_addr_q <= BASE_ADDR;
      wr_data_q <= DATA_SEED;
      exp_q     <= DATA_SEED;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      timeout_q <= 1'b0;
      burst_q   <= '0;
      word_q    <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      exp_q     <= exp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      timeout_q <= timeout_d;
      burst_q   <= burst_d;
      word_q    <= word_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_WR_BURST;
      S_WR_BURST: begin
        if (wr_ack) begin
          if (word_q == W_LAST) state_d = S_WR_GAP;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_DONE;
        end
      end
      S_WR_GAP:   state_d = (burst_q == B_LAST) ? S_RD_BURST : S_WR_BURST;
      S_RD_BURST: begin
        if (rd_ack) begin
          if (word_q == W_LAST) state_d = S_RD_GAP;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_DONE;
        end
      end
      S_RD_GAP:   state_d = (burst_q == B_LAST) ? S_DONE : S_RD_BURST;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Watchdog defaults to zero outside the burst states, so it is clear on burst entry.
  always_comb begin
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    exp_d     = exp_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    timeout_d = timeout_q;
    burst_d   = burst_q;
    word_d    = word_q;
    wdog_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_req_d  = 1'b1;
          wr_addr_d = BASE_ADDR;
          rd_addr_d = BASE_ADDR;
          wr_data_d = DATA_SEED;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_cnt_d = '0;
          timeout_d = 1'b0;
          burst_d   = '0;
          word_d    = '0;
        end
      end
      S_WR_BURST: begin
        if (wr_ack) begin
          wr_data_d = wr_data_q + 16'd1;
          word_d    = word_q + 10'd1;
          if (word_q == W_LAST) begin
            wr_req_d = 1'b0;
            word_d   = '0;
          end
        end else if (wdog_q == WD_LAST) begin
          wr_req_d  = 1'b0;
          rd_req_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_WR_GAP: begin
        if (burst_q == B_LAST) begin
          rd_req_d  = 1'b1;
          rd_addr_d = BASE_ADDR;
          exp_d     = DATA_SEED;
          burst_d   = '0;
        end else begin
          wr_req_d  = 1'b1;
          wr_addr_d = wr_addr_q + STRIDE;
          burst_d   = burst_q + 8'd1;
        end
      end
      S_RD_BURST: begin
        if (rd_ack) begin
          if (rd_data != exp_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          exp_d  = exp_q + 16'd1;
          word_d = word_q + 10'd1;
          if (word_q == W_LAST) begin
            rd_req_d = 1'b0;
            word_d   = '0;
          end
        end else if (wdog_q == WD_LAST) begin
          wr_req_d  = 1'b0;
          rd_req_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_RD_GAP: begin
        if (burst_q != B_LAST) begin
          rd_req_d  = 1'b1;
          rd_addr_d = rd_addr_q + STRIDE;
          burst_d   = burst_q + 8'd1;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_cnt_q == 16'd0) && !timeout_q;
      end
      default: ;
    endcase
  end

  assign wr_req       = wr_req_q;
  assign rd_req       = rd_req_q;
  assign wr_addr      = wr_addr_q;
  assign rd_addr      = rd_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_burst_len = 10'(BURST_LEN);
  assign rd_burst_len = 10'(BURST_LEN);
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_cnt_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/sdram_traffic_gen.md
Name: sdram_traffic_gen

Overview:
- User-side initiator for sdram_ctrl. Drives the wr_req/rd_req burst interface and checks read-back data.
- Writes NUM_BURSTS bursts of a deterministic incrementing pattern, then reads the same region back and compares every word.
- Reports busy/done/pass/error status, for on-board self-test and bench regression against the SDRAM model.

Parameters:
- BASE_ADDR, 24'h00_0000: start address of burst 0.
- BURST_LEN, 10: words per burst. Legal range 1..1023. Also the address stride between bursts.
- NUM_BURSTS, 4: bursts per pass. Legal range 1..255.
- DATA_SEED, 16'h0000: first data word written.
- TIMEOUT_CYC, 4096: maximum cycles to wait for an ack while a request is asserted.

Ports:
- clk_100m, in, 1: system clock.
- rstn, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that launches a test pass.
- wr_req, out, 1: write request to sdram_ctrl, level.
- wr_addr, out, 24: burst start address.
- wr_burst_len, out, 10: equals BURST_LEN.
- wr_data, out, 16: current write word.
- wr_ack, in, 1: controller consumes wr_data on this cycle.
- rd_req, out, 1: read request, level.
- rd_addr, out, 24: burst start address.
- rd_burst_len, out, 10: equals BURST_LEN.
- rd_data, in, 16: read word, valid when rd_ack=1.
- rd_ack, in, 1: read data valid strobe.
- busy, out, 1: pass in progress.
- done, out, 1: pass finished. Sticky until the next start.
- pass, out, 1: done, err_cnt==0 and no timeout.
- err_cnt, out, 16: mismatch count, saturates at 16'hFFFF.
- timeout, out, 1: ack watchdog fired. Sticky until the next start.

Behaviour:
- Reset values: wr_req=0, rd_req=0, wr_addr=rd_addr=BASE_ADDR, wr_data=DATA_SEED, busy=0, done=0, pass=0, err_cnt=0, timeout=0.
- All outputs are registered. wr_burst_len and rd_burst_len are constant BURST_LEN.
- States and transitions:
  - IDLE: on start, go to WR_BURST; clear done, pass, err_cnt, timeout; set busy=1; burst index b=0; data counter=DATA_SEED.
  - WR_BURST: wr_req=1, wr_addr=BASE_ADDR+b*BURST_LEN (mod 2^24).
    - Each cycle with wr_ack=1: word count w++, and wr_data advances to data counter+1 (mod 2^16) on the next edge.
    - On the edge sampling the BURST_LEN-th ack, wr_req drops to 0 and the state goes to WR_GAP.
  - WR_GAP: one cycle with both requests low. Then b++ and go to WR_BURST. After the last burst, go to RD_BURST with b=0 and the expected counter reset to DATA_SEED.
  - RD_BURST: rd_req=1, rd_addr as for writes.
    - Each cycle with rd_ack=1: compare rd_data with the expected value; on mismatch, err_cnt++ (saturating); expected++; w++.
    - On the BURST_LEN-th rd_ack, rd_req drops on that edge and the state goes to RD_GAP.
  - RD_GAP: one cycle. Then the next burst, or DONE after the last one.
  - DONE: busy=0, done=1, pass=(err_cnt==0 && !timeout). Return to IDLE the same cycle; done stays sticky.
- Data pattern:
  - Word k of the pass (k = b*BURST_LEN + w) = DATA_SEED + k, mod 2^16.
  - The read-back check uses the same sequence.
- Watchdog:
  - The counter clears on entering WR_BURST or RD_BURST and on every ack.
  - If it reaches TIMEOUT_CYC while a request is high: drop both requests, set timeout=1, go to DONE (pass=0).
- Stray acks:
  - wr_ack outside WR_BURST and rd_ack outside RD_BURST are ignored.
  - Simultaneous wr_ack and rd_ack: only the one matching the current state is used.
- start while busy: ignored. start in IDLE after a done: starts a fresh pass.
- Reset mid-operation: everything returns to reset values immediately, including requests (asynchronous); no partial status is kept.

Test Plan:
- Ideal responder (ack continuously from the cycle after req, read data echoed from a memory model), defaults, start pulse:
  - writes of 0..39 at addresses 0, 10, 20, 30;
  - reads at the same addresses;
  - done=1, pass=1, err_cnt=0;
  - wr_req low exactly one cycle between bursts.
- Responder with random 0–3-cycle ack gaps, DATA_SEED=16'hFFFE, NUM_BURSTS=2, BURST_LEN=3:
  - written data FFFE, FFFF, 0000, 0001, 0002, 0003 (wrap);
  - pass=1.
- Responder corrupts rd_data of burst 1, word 3 (expected 13) to 16'h00FF:
  - err_cnt=1, pass=0, done=1;
  - all 40 reads still performed.
- Responder never asserts rd_ack, TIMEOUT_CYC=64:
  - rd_req drops 64 cycles after the last reset of the watchdog;
  - timeout=1, done=1, pass=0.
- Deassert rstn during burst 2 of the writes:
  - wr_req=0, busy=0, wr_data=DATA_SEED immediately;
  - a new start after release runs a full pass, pass=1.
- start pulsed while busy: no effect on the sequence. start after done: done clears, err_cnt resets to 0, the pass repeats.
